// File: rtl/dram_pattern_master.sv
// -----------------------------------------------------------------------------
// dram_pattern_master
//
// Wishbone initiator for the 256-bit DRAM wrapper slave port. A start pulse
// writes a deterministic pattern to N consecutive DRAM words. The master then
// reads the words back and compares each one with the pattern. When the run
// ends it reports pass/fail, the number of mismatching words, and the byte
// address of the first mismatch.
//
// Pattern: lane j of word k = (seed + k) ^ (j * 32'h01010101)
// Address: word k lives at base + k * ADDR_STRIDE (mod 2^32)
//
// Ports
//   sys_clk, rst_n        clock, asynchronous active-low reset
//   initialized_i         slave/DRAM ready
//   start_i               start pulse (sampled in IDLE only)
//   base_addr_i           byte address of word 0    (latched at start)
//   word_count_i          number of words N         (latched at start)
//   seed_i                pattern seed              (latched at start)
//   busy_o                run in progress
//   done_o                one-cycle end-of-run pulse
//   pass_o                last run clean            (held)
//   timeout_o             last run aborted on a timeout (held)
//   error_count_o         mismatching words, saturating (held)
//   first_err_addr_o      byte address of first mismatch, 0 if none (held)
//   cyc_o, stb_o, we_o    Wishbone control
//   addr_o, data_o        Wishbone byte address / write data
//   data_i, ack_i         Wishbone read data / single-cycle acknowledge
// -----------------------------------------------------------------------------
module dram_pattern_master #(
  parameter int          WORD_SIZE      = 256,
  parameter int          COUNT_WIDTH    = 16,
  parameter logic [31:0] ADDR_STRIDE    = 32'h80,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   initialized_i,
  input  logic                   start_i,
  input  logic [31:0]            base_addr_i,
  input  logic [COUNT_WIDTH-1:0] word_count_i,
  input  logic [31:0]            seed_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   timeout_o,
  output logic [COUNT_WIDTH-1:0] error_count_o,
  output logic [31:0]            first_err_addr_o,
  output logic                   cyc_o,
  output logic                   stb_o,
  output logic                   we_o,
  output logic [31:0]            addr_o,
  output logic [WORD_SIZE-1:0]   data_o,
  input  logic [WORD_SIZE-1:0]   data_i,
  input  logic                   ack_i
);

  localparam int                     LANES      = WORD_SIZE / 32;
  localparam int                     TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0]     TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INIT,
    S_WR_REQ,
    S_WR_NEXT,
    S_RD_REQ,
    S_RD_NEXT,
    S_FINISH
  } state_t;

  // Build the full word for a given per-word seed (seed + k).
  function automatic logic [WORD_SIZE-1:0] f_pattern(input logic [31:0] word_seed);
    logic [WORD_SIZE-1:0] w;
    w = '0;
    for (int j = 0; j < LANES; j++) begin
      w[j*32 +: 32] = word_seed ^ (32'(j) * 32'h0101_0101);
    end
    return w;
  endfunction

  state_t                 r_state;
  logic [31:0]            r_base;
  logic [31:0]            r_seed;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] r_k;
  logic [31:0]            r_cur_seed;   // seed + k for the word in flight
  logic [TIMER_W-1:0]     r_timer;
  logic                   r_cyc;
  logic                   r_stb;
  logic                   r_we;
  logic [31:0]            r_addr;
  logic [WORD_SIZE-1:0]   r_data;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pass;
  logic                   r_timeout;
  logic [COUNT_WIDTH-1:0] r_err_cnt;
  logic [31:0]            r_first_err_addr;

  logic w_last;
  logic w_timer_expired;
  logic w_mismatch;

  assign w_last          = (r_k == r_count - CNT_ONE);
  assign w_timer_expired = (r_timer == TIMER_LAST);
  // During reads r_data still holds the expected pattern for word k, so the
  // compare uses the same register that drives the write data.
  assign w_mismatch      = (data_i != r_data);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_base           <= '0;
      r_seed           <= '0;
      r_count          <= '0;
      r_k              <= '0;
      r_cur_seed       <= '0;
      r_timer          <= '0;
      r_cyc            <= 1'b0;
      r_stb            <= 1'b0;
      r_we             <= 1'b0;
      r_addr           <= '0;
      r_data           <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_timeout        <= 1'b0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
    end else begin
      // NOTE: every state register uses <= so that all branches read the
      // values from before this edge, whatever the statement order.
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_base           <= base_addr_i;
            r_seed           <= seed_i;
            r_count          <= word_count_i;
            r_k              <= '0;
            r_cur_seed       <= seed_i;
            r_addr           <= base_addr_i;
            r_data           <= f_pattern(seed_i);
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_pass           <= 1'b0;
            r_timeout        <= 1'b0;
            r_busy           <= 1'b1;
            r_state          <= S_WAIT_INIT;
          end
        end

        S_WAIT_INIT: begin
          if (initialized_i) begin
            if (r_count == '0) begin
              r_pass  <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_we    <= 1'b1;
              r_timer <= '0;
              r_state <= S_WR_REQ;
            end
          end
        end

        S_WR_REQ, S_RD_REQ: begin
          if (ack_i) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            if (r_state == S_WR_REQ) begin
              r_state <= S_WR_NEXT;
            end else begin
              if (w_mismatch) begin
                if (r_err_cnt == '0) begin
                  r_first_err_addr <= r_addr;
                end
                if (r_err_cnt != '1) begin
                  r_err_cnt <= r_err_cnt + CNT_ONE;
                end
              end
              r_state <= S_RD_NEXT;
            end
          end else if (w_timer_expired) begin
            // Abandon the request: the slave never acknowledged it.
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_FINISH;
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end

        S_WR_NEXT: begin
          r_cyc   <= 1'b1;
          r_stb   <= 1'b1;
          r_timer <= '0;
          if (w_last) begin
            // Write phase complete: rewind to word 0 for the read-back.
            r_k        <= '0;
            r_cur_seed <= r_seed;
            r_addr     <= r_base;
            r_data     <= f_pattern(r_seed);
            r_we       <= 1'b0;
            r_state    <= S_RD_REQ;
          end else begin
            r_k        <= r_k + CNT_ONE;
            r_cur_seed <= r_cur_seed + 32'd1;
            r_addr     <= r_addr + ADDR_STRIDE;
            r_data     <= f_pattern(r_cur_seed + 32'd1);
            r_we       <= 1'b1;
            r_state    <= S_WR_REQ;
          end
        end

        S_RD_NEXT: begin
          if (w_last) begin
            r_pass  <= (r_err_cnt == '0);
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_k        <= r_k + CNT_ONE;
            r_cur_seed <= r_cur_seed + 32'd1;
            r_addr     <= r_addr + ADDR_STRIDE;
            r_data     <= f_pattern(r_cur_seed + 32'd1);
            r_cyc      <= 1'b1;
            r_stb      <= 1'b1;
            r_we       <= 1'b0;
            r_timer    <= '0;
            r_state    <= S_RD_REQ;
          end
        end

        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobe is masked in the ack cycle so the slave never sees a second request
  // before the registered cyc/stb drop on the following edge.
  assign cyc_o            = r_cyc & ~ack_i;
  assign stb_o            = r_stb & ~ack_i;
  assign we_o             = r_we;
  assign addr_o           = r_addr;
  assign data_o           = r_data;
  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign pass_o           = r_pass;
  assign timeout_o        = r_timeout;
  assign error_count_o    = r_err_cnt;
  assign first_err_addr_o = r_first_err_addr;

endmodule

// File: tb/tb_dram_pattern_master.sv
// -----------------------------------------------------------------------------
// tb_dram_pattern_master
//
// Directed bench for dram_pattern_master. A Wishbone slave model acknowledges
// requests after a fixed latency and keeps the words that were written, so it
// can return them on reads. It can corrupt one lane on readback or stop
// acknowledging altogether. The expected bus transactions for each run go into
// a scoreboard queue when the run starts. They are popped and compared at every
// acknowledge.
// -----------------------------------------------------------------------------
module tb_dram_pattern_master;

  localparam int WS      = 256;
  localparam int CW      = 16;
  localparam int ACK_LAT = 5;
  localparam int TO_CYC  = 16;
  localparam logic [WS-1:0] CORRUPT_MASK = WS'(1) << 96;   // lane 3, bit 0

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [WS-1:0] data;
  } txn_t;

  logic          sys_clk;
  logic          rst_n;
  logic          initialized_i;
  logic          start_i;
  logic [31:0]   base_addr_i;
  logic [CW-1:0] word_count_i;
  logic [31:0]   seed_i;
  logic          busy_o, done_o, pass_o, timeout_o;
  logic [CW-1:0] error_count_o;
  logic [31:0]   first_err_addr_o;
  logic          cyc_o, stb_o, we_o;
  logic [31:0]   addr_o;
  logic [WS-1:0] data_o;
  logic [WS-1:0] data_i;
  logic          ack_i;

  dram_pattern_master #(
    .WORD_SIZE      (WS),
    .COUNT_WIDTH    (CW),
    .ADDR_STRIDE    (32'h80),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .sys_clk          (sys_clk),
    .rst_n            (rst_n),
    .initialized_i    (initialized_i),
    .start_i          (start_i),
    .base_addr_i      (base_addr_i),
    .word_count_i     (word_count_i),
    .seed_i           (seed_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .pass_o           (pass_o),
    .timeout_o        (timeout_o),
    .error_count_o    (error_count_o),
    .first_err_addr_o (first_err_addr_o),
    .cyc_o            (cyc_o),
    .stb_o            (stb_o),
    .we_o             (we_o),
    .addr_o           (addr_o),
    .data_o           (data_o),
    .data_i           (data_i),
    .ack_i            (ack_i)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // ---------------- slave model ----------------
  bit            slave_en;
  bit            corrupt_en;
  logic [31:0]   corrupt_addr;
  logic          r_ack;
  logic [WS-1:0] r_rdata;
  int            wait_cnt;
  logic [WS-1:0] mem [0:63];

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack    <= 1'b0;
      wait_cnt <= 0;
      r_rdata  <= '0;
    end else if (r_ack) begin
      r_ack    <= 1'b0;
      wait_cnt <= 0;
    end else if (slave_en && cyc_o && stb_o) begin
      if (wait_cnt == ACK_LAT - 2) begin
        r_ack    <= 1'b1;
        wait_cnt <= 0;
        if (we_o) mem[addr_o[12:7]] <= data_o;
        else      r_rdata <= mem[addr_o[12:7]] ^
                             ((corrupt_en && addr_o == corrupt_addr) ? CORRUPT_MASK : '0);
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  assign ack_i  = r_ack;
  // Junk outside the ack cycle: the master must only look at data_i with ack.
  assign data_i = r_ack ? r_rdata : {8{32'hDEAD_BEEF}};

  // ---------------- bus activity monitor ----------------
  int stb_cycles, stb_rises, ack_total, cyc_cycles;
  bit prev_stb;

  always @(negedge sys_clk) begin
    if (stb_o) stb_cycles <= stb_cycles + 1;
    if (stb_o && !prev_stb) stb_rises <= stb_rises + 1;
    prev_stb <= stb_o;
    if (ack_i) ack_total <= ack_total + 1;
    if (cyc_o) cyc_cycles <= cyc_cycles + 1;
  end

  // ---------------- checking helpers ----------------
  int   n_checks;
  int   n_errors;
  txn_t sb[$];

  task automatic check(input string tag, input logic [WS-1:0] obs, input logic [WS-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WS-1:0] exp_word(input logic [31:0] s);
    logic [WS-1:0] w;
    logic [7:0]    j8;
    for (int j = 0; j < WS/32; j++) begin
      j8 = 8'(j);
      w[j*32 +: 32] = s ^ {j8, j8, j8, j8};
    end
    return w;
  endfunction

  task automatic push_expected(input logic [31:0] base, input int n, input logic [31:0] seed);
    txn_t t;
    sb.delete();
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < n; k++) begin
        t.we   = (ph == 0);
        t.addr = base + 32'(k) * 32'h80;
        t.data = exp_word(seed + 32'(k));
        sb.push_back(t);
      end
    end
  endtask

  task automatic sb_compare();
    txn_t t;
    check("sb_has_entry", WS'(sb.size() != 0), WS'(1));
    if (sb.size() != 0) begin
      t = sb.pop_front();
      check("bus_we", WS'(we_o), WS'(t.we));
      check("bus_addr", WS'(addr_o), WS'(t.addr));
      if (t.we) check("bus_wdata", data_o, t.data);
    end
  endtask

  // Called at a negedge; start is seen on the following posedge.
  task automatic start_run(input logic [31:0] base, input int n, input logic [31:0] seed);
    base_addr_i  = base;
    word_count_i = CW'(n);
    seed_i       = seed;
    start_i      = 1'b1;
    @(negedge sys_clk);
    start_i      = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int waited);
    bit got;
    got    = 0;
    waited = 0;
    while (!got && waited < budget) begin
      @(negedge sys_clk);
      waited++;
      if (ack_i) sb_compare();
      if (done_o) got = 1;
    end
    check("done_within_budget", WS'(got), WS'(1));
    @(negedge sys_clk);
    check("done_one_cycle", WS'(done_o), WS'(0));
    check("busy_after_done", WS'(busy_o), WS'(0));
  endtask

  int s_stb_c, s_stb_r, s_ack, s_cyc;
  task automatic snapshot();
    s_stb_c = stb_cycles;
    s_stb_r = stb_rises;
    s_ack   = ack_total;
    s_cyc   = cyc_cycles;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int waited;
    int acks;

    rst_n         = 1'b0;
    initialized_i = 1'b1;
    start_i       = 1'b0;
    base_addr_i   = '0;
    word_count_i  = '0;
    seed_i        = '0;
    slave_en      = 1'b1;
    corrupt_en    = 1'b0;
    corrupt_addr  = '0;

    repeat (3) @(negedge sys_clk);
    check("reset_ctrl_outputs",
          WS'({busy_o, done_o, pass_o, timeout_o, error_count_o, first_err_addr_o,
               cyc_o, stb_o, we_o, addr_o}), '0);
    check("reset_data_o", data_o, '0);
    rst_n = 1'b1;
    @(negedge sys_clk);

    // Clean run: 4 words, 5-cycle ack latency.
    push_expected(32'h1000, 4, 32'h1111_0000);
    snapshot();
    start_run(32'h1000, 4, 32'h1111_0000);
    check("busy_after_start", WS'(busy_o), WS'(1));
    wait_done(300, waited);
    check("run_length_cycles", WS'(waited + 1), WS'(1 + 2 * 4 * (ACK_LAT + 1) + 1));
    check("clean_pass", WS'(pass_o), WS'(1));
    check("clean_err_cnt", WS'(error_count_o), WS'(0));
    check("clean_first_addr", WS'(first_err_addr_o), WS'(0));
    check("clean_timeout", WS'(timeout_o), WS'(0));
    check("clean_ack_count", WS'(ack_total - s_ack), WS'(8));
    check("clean_strobe_count", WS'(stb_rises - s_stb_r), WS'(8));
    check("clean_sb_drained", WS'(sb.size()), WS'(0));
    check("word2_lane0", WS'(mem[6'h22][31:0]), WS'(32'h1111_0002));

    // Same run, lane 3 of word 1 corrupted on readback.
    corrupt_en   = 1'b1;
    corrupt_addr = 32'h1080;
    push_expected(32'h1000, 4, 32'h1111_0000);
    start_run(32'h1000, 4, 32'h1111_0000);
    check("pass_cleared_at_start", WS'(pass_o), WS'(0));
    wait_done(300, waited);
    corrupt_en = 1'b0;
    check("corrupt_pass", WS'(pass_o), WS'(0));
    check("corrupt_err_cnt", WS'(error_count_o), WS'(1));
    check("corrupt_first_addr", WS'(first_err_addr_o), WS'(32'h1080));
    check("corrupt_sb_drained", WS'(sb.size()), WS'(0));

    // N = 0: no bus traffic, done right after WAIT_INIT.
    sb.delete();
    snapshot();
    start_run(32'h1000, 0, 32'h0);
    wait_done(20, waited);
    check("n0_done_latency", WS'(waited), WS'(1));
    check("n0_pass", WS'(pass_o), WS'(1));
    check("n0_err_cnt", WS'(error_count_o), WS'(0));
    check("n0_no_cyc", WS'(cyc_cycles - s_cyc), WS'(0));

    // Slave not ready for 100 cycles; addresses and seed wrap past 2^32.
    initialized_i = 1'b0;
    push_expected(32'hFFFF_FF80, 3, 32'hFFFF_FFFE);
    snapshot();
    start_run(32'hFFFF_FF80, 3, 32'hFFFF_FFFE);
    repeat (100) @(negedge sys_clk);
    check("init_hold_no_strobe", WS'(stb_rises - s_stb_r), WS'(0));
    check("init_hold_busy", WS'(busy_o), WS'(1));
    initialized_i = 1'b1;
    wait_done(300, waited);
    check("init_pass", WS'(pass_o), WS'(1));
    check("init_ack_count", WS'(ack_total - s_ack), WS'(6));
    check("init_sb_drained", WS'(sb.size()), WS'(0));

    // Slave never acknowledges: timeout after TO_CYC strobe cycles.
    slave_en = 1'b0;
    sb.delete();
    snapshot();
    start_run(32'h2000, 2, 32'h0);
    wait_done(200, waited);
    slave_en = 1'b1;
    check("to_stb_cycles", WS'(stb_cycles - s_stb_c), WS'(TO_CYC));
    check("to_timeout", WS'(timeout_o), WS'(1));
    check("to_pass", WS'(pass_o), WS'(0));
    check("to_cyc_low", WS'(cyc_o), WS'(0));

    // Reset in the middle of the third write.
    push_expected(32'h3000, 4, 32'hA5A5_0000);
    start_run(32'h3000, 4, 32'hA5A5_0000);
    check("timeout_cleared_at_start", WS'(timeout_o), WS'(0));
    acks = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (ack_i) begin
        sb_compare();
        acks++;
      end
      if (acks == 2 && stb_o) break;
    end
    check("third_write_addr", WS'(addr_o), WS'(32'h3100));
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_ctrl",
          WS'({busy_o, done_o, pass_o, timeout_o, error_count_o, first_err_addr_o,
               cyc_o, stb_o, we_o, addr_o, ack_i}), '0);
    check("midrun_reset_data", data_o, '0);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);

    push_expected(32'h4000, 4, 32'h5A5A_0000);
    snapshot();
    start_run(32'h4000, 4, 32'h5A5A_0000);
    wait_done(300, waited);
    check("post_reset_pass", WS'(pass_o), WS'(1));
    check("post_reset_err_cnt", WS'(error_count_o), WS'(0));
    check("post_reset_acks", WS'(ack_total - s_ack), WS'(8));
    check("post_reset_sb_drained", WS'(sb.size()), WS'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dram_pattern_master.md
# dram_pattern_master

Wishbone initiator that drives the 256-bit DRAM wrapper slave port on `sys_clk`. On a start pulse it writes a deterministic pattern to N consecutive DRAM words, reads them back, compares, and reports pass/fail with an error count and first failing address. It is the bring-up and regression traffic source sitting directly on the wrapper's `cyc/stb/we/addr/data/ack` port.

## Interface
- `WORD_SIZE`, 256, data width; multiple of 32.
- `COUNT_WIDTH`, 16, width of word count and error count.
- `ADDR_STRIDE`, 32'h80, byte increment per word; the slave decodes `addr[31:7]`.
- `TIMEOUT_CYCLES`, 4096, max cycles a request may wait for `ack_i`.

- `sys_clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `initialized_i` in 1: slave/DRAM ready.
- `start_i` in 1: start pulse, sampled only in IDLE.
- `base_addr_i` in 32: byte address of word 0, latched at start.
- `word_count_i` in COUNT_WIDTH: number of words N, latched at start.
- `seed_i` in 32: pattern seed, latched at start.
- `busy_o` out 1: run in progress.
- `done_o` out 1: one-cycle pulse at end of run.
- `pass_o` out 1: last run clean; held until next start.
- `timeout_o` out 1: last run aborted on timeout; held.
- `error_count_o` out COUNT_WIDTH: mismatching words, saturating; held.
- `first_err_addr_o` out 32: byte address of first mismatch; held, 0 if none.
- `cyc_o`, `stb_o` out 1: Wishbone cycle/strobe.
- `we_o` out 1: write enable.
- `addr_o` out 32: byte address.
- `data_o` out WORD_SIZE: write data.
- `data_i` in WORD_SIZE: read data.
- `ack_i` in 1: single-cycle acknowledge.

## Operation
- Pattern: 32-bit lane j of word k is `(seed + k) ^ (j * 32'h01010101)`, mod 2^32 arithmetic, k = 0..N-1, j = 0..WORD_SIZE/32-1.
- Address of word k: `base + k*ADDR_STRIDE`, mod 2^32; wraps silently.
- States: IDLE, WAIT_INIT, WR_REQ, WR_NEXT, RD_REQ, RD_NEXT, FINISH.
- IDLE: on `start_i` latch base/count/seed; clear error_count, first_err_addr, pass, timeout; k=0; go WAIT_INIT. `start_i` outside IDLE is ignored.
- WAIT_INIT: stay until `initialized_i`=1. If N=0 go FINISH (pass=1, no bus traffic); else WR_REQ.
- WR_REQ: `cyc=stb=we=1`, addr/data for word k. On `ack_i` go WR_NEXT.
- WR_NEXT: bus idle one cycle; if k=N-1 set k=0, go RD_REQ; else k+1, WR_REQ.
- RD_REQ: `cyc=stb=1`, `we=0`, addr of word k. On `ack_i` compare `data_i` with expected pattern; on mismatch increment error_count (saturate at all-ones) and, if first, record address. Go RD_NEXT.
- RD_NEXT: bus idle one cycle; if k=N-1 go FINISH, else k+1, RD_REQ.
- Timeout: per-request counter cleared on entering WR_REQ/RD_REQ; reaching TIMEOUT_CYCLES without ack drops cyc/stb, sets timeout_o=1 and pass=0, goes FINISH.
- FINISH: `done_o`=1 for one cycle; pass = (error_count==0 && !timeout); go IDLE.
- Reset mid-run: all state and outputs return to reset values immediately; the in-flight request is abandoned.

## Timing
- Reset values: all outputs 0 (`addr_o`, `data_o` 0; `pass_o` 0).
- `cyc_o`/`stb_o` are registered and combinationally masked low in any cycle `ack_i`=1, so the slave never sees strobe in the ack cycle and captures no duplicate request.
- `we_o`, `addr_o`, `data_o` are registered and stable while `stb_o` is high.
- `busy_o` is high from the cycle after start acceptance until the cycle `done_o` pulses, inclusive.
- Minimum run length: 1 (WAIT_INIT) + 2N×(ack latency + 1) + 1 (FINISH) cycles.
- Compare uses `data_i` in the ack cycle only; `data_i` in other cycles is ignored.
- An `ack_i` arriving outside WR_REQ/RD_REQ is ignored.

## Test plan
- Slave model with 5-cycle ack latency, `initialized_i`=1, base=0x1000, N=4, seed=0x11110000: four writes at 0x1000/0x1080/0x1100/0x1180, then four reads, with lane 0 of word 2 = 0x11110002. Required: `done_o` pulse, `pass_o`=1, error_count=0, exactly 8 acks and no extra strobes.
- Same run, with the model corrupting lane 3 of word 1 on readback. Required: `pass_o`=0, error_count=1, first_err_addr=0x1080.
- N=0. Required: `done_o` one cycle after WAIT_INIT exits, `pass_o`=1, `cyc_o` never high.
- Hold `initialized_i`=0 for 100 cycles after start. Required: no strobe until `initialized_i` rises, then a normal pass.
- Model never acks and TIMEOUT_CYCLES=16. Required: `stb_o` drops after 16 cycles, `timeout_o`=1, `pass_o`=0, `done_o` pulses.
- Deassert `rst_n` during the third write. Required: all outputs 0 asynchronously; a subsequent start runs cleanly to pass.
